// File: rtl/cic_d_rate_ctrl.sv
// Rate-change sequencer for a variable-rate cic_d: range-checks rate requests, stalls and drains
// the input, issues one rate write, then blanks the comb transient until outputs have settled.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// RUN    | normal streaming; rate requests accepted here only
// DRAIN  | input stalled for DRAIN_CYCLES; old-rate outputs still forwarded
// APPLY  | one-cycle rate write strobe to cic_d; outputs blanked
// SETTLE | input resumes; first SETTLE_OUTPUTS cic_d outputs discarded
module cic_d_rate_ctrl #(
   parameter int INP_DW         = 32,
   parameter int OUT_DW         = 32,
   parameter int RATE_DW        = 32,
   parameter int CIC_R          = 10,
   parameter int CIC_N          = 7,
   parameter int CIC_M          = 1,
   parameter int DRAIN_CYCLES   = 16,
   parameter int SETTLE_OUTPUTS = CIC_N * CIC_M
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [RATE_DW-1:0] s_axis_cfg_tdata,
   input  logic               s_axis_cfg_tvalid,
   output logic               s_axis_cfg_tready,
   input  logic [INP_DW-1:0]  s_axis_in_tdata,
   input  logic               s_axis_in_tvalid,
   output logic               s_axis_in_tready,
   output logic [INP_DW-1:0]  m_axis_cic_tdata,
   output logic               m_axis_cic_tvalid,
   output logic [RATE_DW-1:0] m_axis_rate_tdata,
   output logic               m_axis_rate_tvalid,
   input  logic [OUT_DW-1:0]  s_axis_cic_out_tdata,
   input  logic               s_axis_cic_out_tvalid,
   output logic [OUT_DW-1:0]  m_axis_out_tdata,
   output logic               m_axis_out_tvalid,
   output logic [RATE_DW-1:0] cur_rate,
   output logic               busy,
   output logic               cfg_err
);

   localparam int DRAIN_W  = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
   localparam int SETTLE_W = (SETTLE_OUTPUTS > 0) ? $clog2(SETTLE_OUTPUTS + 1) : 1;
   localparam logic [DRAIN_W-1:0]  DRAIN_LAST = DRAIN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
   localparam logic [SETTLE_W-1:0] SETTLE_TC  = SETTLE_W'(SETTLE_OUTPUTS);
   localparam logic [RATE_DW-1:0]  RATE_MAX   = RATE_DW'(CIC_R);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_DRAIN,
      ST_APPLY,
      ST_SETTLE
   } state_t;

   state_t               state_q, state_d;
   logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
   logic [SETTLE_W-1:0]  settle_cnt_q, settle_cnt_d;
   logic [RATE_DW-1:0]   new_rate_q, new_rate_d;
   logic [RATE_DW-1:0]   cur_rate_q, cur_rate_d;
   logic [RATE_DW-1:0]   rate_tdata_q, rate_tdata_d;
   logic                 rate_tvalid_q, rate_tvalid_d;
   logic                 cfg_err_q, cfg_err_d;
   logic [OUT_DW-1:0]    out_tdata_q;
   logic                 out_tvalid_q;
   logic                 cfg_fire;
   logic                 rate_bad;
   logic                 blank;
   logic                 out_fwd;

   assign cfg_fire = s_axis_cfg_tvalid && (state_q == ST_RUN);
   assign rate_bad = (s_axis_cfg_tdata == '0) || (s_axis_cfg_tdata > RATE_MAX);
   assign blank    = (state_q == ST_APPLY) || (state_q == ST_SETTLE);
   assign out_fwd  = s_axis_cic_out_tvalid && !blank;

   assign s_axis_cfg_tready  = (state_q == ST_RUN);
   assign s_axis_in_tready   = (state_q != ST_DRAIN);
   assign m_axis_cic_tdata   = s_axis_in_tdata;
   assign m_axis_cic_tvalid  = s_axis_in_tvalid && s_axis_in_tready;
   assign m_axis_rate_tdata  = rate_tdata_q;
   assign m_axis_rate_tvalid = rate_tvalid_q;
   assign m_axis_out_tdata   = out_tdata_q;
   assign m_axis_out_tvalid  = out_tvalid_q;
   assign cur_rate           = cur_rate_q;
   assign busy               = (state_q != ST_RUN);
   assign cfg_err            = cfg_err_q;

   always_comb begin
      state_d       = state_q;
      drain_cnt_d   = drain_cnt_q;
      settle_cnt_d  = settle_cnt_q;
      new_rate_d    = new_rate_q;
      cur_rate_d    = cur_rate_q;
      rate_tdata_d  = rate_tdata_q;
      rate_tvalid_d = 1'b0;
      cfg_err_d     = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (cfg_fire) begin
               if (rate_bad) begin
                  cfg_err_d = 1'b1;
               end else if (s_axis_cfg_tdata != cur_rate_q) begin
                  new_rate_d  = s_axis_cfg_tdata;
                  drain_cnt_d = '0;
                  state_d     = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            // Strobe is registered so it lines up exactly with the APPLY cycle.
            if (drain_cnt_q == DRAIN_LAST) begin
               rate_tvalid_d = 1'b1;
               rate_tdata_d  = new_rate_q;
               state_d       = ST_APPLY;
            end else begin
               drain_cnt_d = drain_cnt_q + 1'b1;
            end
         end
         ST_APPLY: begin
            cur_rate_d   = new_rate_q;
            settle_cnt_d = '0;
            state_d      = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (SETTLE_OUTPUTS == 0) begin
               state_d = ST_RUN;
            end else if (s_axis_cic_out_tvalid) begin
               settle_cnt_d = settle_cnt_q + 1'b1;
               if (settle_cnt_d == SETTLE_TC) begin
                  state_d = ST_RUN;
               end
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= ST_RUN;
         drain_cnt_q   <= '0;
         settle_cnt_q  <= '0;
         new_rate_q    <= RATE_MAX;
         cur_rate_q    <= RATE_MAX;
         rate_tdata_q  <= RATE_MAX;
         rate_tvalid_q <= 1'b0;
         cfg_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         drain_cnt_q   <= drain_cnt_d;
         settle_cnt_q  <= settle_cnt_d;
         new_rate_q    <= new_rate_d;
         cur_rate_q    <= cur_rate_d;
         rate_tdata_q  <= rate_tdata_d;
         rate_tvalid_q <= rate_tvalid_d;
         cfg_err_q     <= cfg_err_d;
      end
   end

   // Blanked samples leave tdata holding its last settled value.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_tvalid_q <= 1'b0;
         out_tdata_q  <= '0;
      end else begin
         out_tvalid_q <= out_fwd;
         if (out_fwd) begin
            out_tdata_q <= s_axis_cic_out_tdata;
         end
      end
   end

endmodule

// File: tb/tb_cic_d_rate_ctrl.sv
// Self-checking bench for cic_d_rate_ctrl: table-driven rate-change vectors, hand sequences
// for held requests and mid-drain reset, and a scoreboard on the gated output stream.
module tb_cic_d_rate_ctrl;
   localparam int INP_DW       = 16;
   localparam int OUT_DW       = 24;
   localparam int RATE_DW      = 8;
   localparam int CIC_R        = 10;
   localparam int CIC_N        = 3;
   localparam int CIC_M        = 1;
   localparam int DRAIN_CYCLES = 8;

   logic               clk;
   logic               reset_n;
   logic [RATE_DW-1:0] s_axis_cfg_tdata;
   logic               s_axis_cfg_tvalid;
   logic               s_axis_cfg_tready;
   logic [INP_DW-1:0]  s_axis_in_tdata;
   logic               s_axis_in_tvalid;
   logic               s_axis_in_tready;
   logic [INP_DW-1:0]  m_axis_cic_tdata;
   logic               m_axis_cic_tvalid;
   logic [RATE_DW-1:0] m_axis_rate_tdata;
   logic               m_axis_rate_tvalid;
   logic [OUT_DW-1:0]  s_axis_cic_out_tdata;
   logic               s_axis_cic_out_tvalid;
   logic [OUT_DW-1:0]  m_axis_out_tdata;
   logic               m_axis_out_tvalid;
   logic [RATE_DW-1:0] cur_rate;
   logic               busy;
   logic               cfg_err;

   cic_d_rate_ctrl #(
      .INP_DW(INP_DW), .OUT_DW(OUT_DW), .RATE_DW(RATE_DW), .CIC_R(CIC_R),
      .CIC_N(CIC_N), .CIC_M(CIC_M), .DRAIN_CYCLES(DRAIN_CYCLES)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .s_axis_cfg_tdata(s_axis_cfg_tdata), .s_axis_cfg_tvalid(s_axis_cfg_tvalid),
      .s_axis_cfg_tready(s_axis_cfg_tready),
      .s_axis_in_tdata(s_axis_in_tdata), .s_axis_in_tvalid(s_axis_in_tvalid),
      .s_axis_in_tready(s_axis_in_tready),
      .m_axis_cic_tdata(m_axis_cic_tdata), .m_axis_cic_tvalid(m_axis_cic_tvalid),
      .m_axis_rate_tdata(m_axis_rate_tdata), .m_axis_rate_tvalid(m_axis_rate_tvalid),
      .s_axis_cic_out_tdata(s_axis_cic_out_tdata), .s_axis_cic_out_tvalid(s_axis_cic_out_tvalid),
      .m_axis_out_tdata(m_axis_out_tdata), .m_axis_out_tvalid(m_axis_out_tvalid),
      .cur_rate(cur_rate), .busy(busy), .cfg_err(cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic               cv;
      logic [RATE_DW-1:0] cd;
      logic               ov;
      logic               fwd;
      logic               e_in_rdy;
      logic               e_busy;
      logic               e_rtv;
      logic [RATE_DW-1:0] e_rd;
      logic [RATE_DW-1:0] e_cur;
      logic               e_err;
   } vec_t;

   vec_t              tbl [21];
   logic [OUT_DW-1:0] exp_q [$];
   logic [OUT_DW-1:0] exp_v;
   logic [INP_DW-1:0] last_in;
   logic              prev_rtv;
   int                checks;
   int                errors;
   int                rate_pulses;
   int                sample_ctr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic cv, input int cd, input logic ov, input logic fwd,
                               input logic e_in_rdy, input logic e_busy, input logic e_rtv,
                               input int e_rd, input int e_cur, input logic e_err);
      vec_t v;
      v.cv = cv; v.cd = RATE_DW'(cd); v.ov = ov; v.fwd = fwd;
      v.e_in_rdy = e_in_rdy; v.e_busy = e_busy; v.e_rtv = e_rtv;
      v.e_rd = RATE_DW'(e_rd); v.e_cur = RATE_DW'(e_cur); v.e_err = e_err;
      return v;
   endfunction

   // Expected output stream: forwarded samples are queued when driven, popped when they emerge.
   always @(negedge clk) begin
      if (m_axis_out_tvalid) begin
         chk("out_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            chk("out_tdata", 32'(m_axis_out_tdata), 32'(exp_v));
         end
      end
      if (m_axis_rate_tvalid) begin
         rate_pulses++;
         chk("rate_tvalid_single", 32'(prev_rtv), 32'd0);
      end
      prev_rtv = m_axis_rate_tvalid;
   end

   task automatic step(input logic cv, input logic [RATE_DW-1:0] cd, input logic ov, input logic fwd);
      s_axis_cfg_tvalid     = cv;
      s_axis_cfg_tdata      = cd;
      s_axis_in_tvalid      = 1'b1;
      s_axis_in_tdata       = INP_DW'(sample_ctr * 7 + 5);
      last_in               = s_axis_in_tdata;
      s_axis_cic_out_tvalid = ov;
      s_axis_cic_out_tdata  = OUT_DW'(sample_ctr * 3 + 1);
      if (ov && fwd) exp_q.push_back(s_axis_cic_out_tdata);
      sample_ctr++;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n               = 1'b0;
      s_axis_cfg_tvalid     = 1'b0;
      s_axis_cfg_tdata      = '0;
      s_axis_in_tvalid      = 1'b0;
      s_axis_in_tdata       = '0;
      s_axis_cic_out_tvalid = 1'b0;
      s_axis_cic_out_tdata  = '0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      reset_n = 1'b1;
   endtask

   // Edge index n counted from the accept of rate 5; outputs around each APPLY/SETTLE are discarded.
   function automatic logic fwd5(input int n);
      return !((n >= 9 && n <= 12) || (n >= 22 && n <= 25));
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int n;
      int rtv_n;
      int base;
      checks = 0; errors = 0; rate_pulses = 0; sample_ctr = 0; prev_rtv = 1'b0;

      tbl[0]  = mk(1, 0,  1, 1,  1, 0, 0, 0, 10, 1);
      tbl[1]  = mk(0, 0,  1, 1,  1, 0, 0, 0, 10, 0);
      tbl[2]  = mk(1, 11, 0, 1,  1, 0, 0, 0, 10, 1);
      tbl[3]  = mk(0, 0,  1, 1,  1, 0, 0, 0, 10, 0);
      tbl[4]  = mk(1, 10, 1, 1,  1, 0, 0, 0, 10, 0);
      tbl[5]  = mk(0, 0,  0, 1,  1, 0, 0, 0, 10, 0);
      tbl[6]  = mk(1, 5,  1, 1,  0, 1, 0, 0, 10, 0);
      for (int i = 7; i <= 13; i++) tbl[i] = mk(0, 0, 1, 1, 0, 1, 0, 0, 10, 0);
      tbl[14] = mk(0, 0,  1, 1,  1, 1, 1, 5, 10, 0);
      tbl[15] = mk(0, 0,  1, 0,  1, 1, 0, 0, 5,  0);
      tbl[16] = mk(0, 0,  1, 0,  1, 1, 0, 0, 5,  0);
      tbl[17] = mk(0, 0,  1, 0,  1, 1, 0, 0, 5,  0);
      tbl[18] = mk(0, 0,  1, 0,  1, 0, 0, 0, 5,  0);
      tbl[19] = mk(0, 0,  1, 1,  1, 0, 0, 0, 5,  0);
      tbl[20] = mk(0, 0,  1, 1,  1, 0, 0, 0, 5,  0);

      // Reset and idle
      do_reset();
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      chk("rst_cur_rate", 32'(cur_rate), 32'd10);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cfg_tready", 32'(s_axis_cfg_tready), 32'd1);
      chk("rst_in_tready", 32'(s_axis_in_tready), 32'd1);
      chk("rst_cic_tvalid", 32'(m_axis_cic_tvalid), 32'd0);
      chk("rst_rate_tvalid", 32'(m_axis_rate_tvalid), 32'd0);
      chk("rst_out_tvalid", 32'(m_axis_out_tvalid), 32'd0);
      chk("rst_out_tdata", 32'(m_axis_out_tdata), 32'd0);
      chk("rst_cfg_err", 32'(cfg_err), 32'd0);

      // Rejected, no-op and full change to rate 5
      base = rate_pulses;
      for (int i = 0; i < 21; i++) begin
         step(tbl[i].cv, tbl[i].cd, tbl[i].ov, tbl[i].fwd);
         chk($sformatf("v%0d_in_tready", i), 32'(s_axis_in_tready), 32'(tbl[i].e_in_rdy));
         chk($sformatf("v%0d_cic_tvalid", i), 32'(m_axis_cic_tvalid), 32'(tbl[i].e_in_rdy));
         chk($sformatf("v%0d_cic_tdata", i), 32'(m_axis_cic_tdata), 32'(last_in));
         chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
         chk($sformatf("v%0d_cfg_tready", i), 32'(s_axis_cfg_tready), 32'(!tbl[i].e_busy));
         chk($sformatf("v%0d_rate_tvalid", i), 32'(m_axis_rate_tvalid), 32'(tbl[i].e_rtv));
         chk($sformatf("v%0d_cur_rate", i), 32'(cur_rate), 32'(tbl[i].e_cur));
         chk($sformatf("v%0d_cfg_err", i), 32'(cfg_err), 32'(tbl[i].e_err));
         if (tbl[i].e_rtv) chk($sformatf("v%0d_rate_tdata", i), 32'(m_axis_rate_tdata), 32'(tbl[i].e_rd));
      end
      chk("tbl_rate_pulses", 32'(rate_pulses - base), 32'd1);

      // Request for 4 held while the change to 5 is in progress
      do_reset();
      base = rate_pulses;
      n = 0;
      step(1'b1, 8'd5, 1'b1, fwd5(0));
      chk("s5_cfg_tready_drop", 32'(s_axis_cfg_tready), 32'd0);
      for (int k = 1; k <= 2; k++) begin
         n = k;
         step(1'b0, 8'd0, 1'b1, fwd5(n));
      end
      while (s_axis_cfg_tready !== 1'b1 && n < 40) begin
         n++;
         step(1'b1, 8'd4, 1'b1, fwd5(n));
      end
      chk("s5_tready_return_edge", 32'(n), 32'd12);
      chk("s5_cur_rate_5", 32'(cur_rate), 32'd5);
      n++;
      step(1'b1, 8'd4, 1'b1, fwd5(n));
      chk("s5_second_busy", 32'(busy), 32'd1);
      chk("s5_second_in_tready", 32'(s_axis_in_tready), 32'd0);
      rtv_n = -1;
      while (busy && n < 60) begin
         n++;
         step(1'b0, 8'd0, 1'b1, fwd5(n));
         if (m_axis_rate_tvalid) begin
            rtv_n = n;
            chk("s5_rate_tdata", 32'(m_axis_rate_tdata), 32'd4);
         end
      end
      chk("s5_rate_edge", 32'(rtv_n), 32'd21);
      chk("s5_run_edge", 32'(n), 32'd25);
      chk("s5_cur_rate_4", 32'(cur_rate), 32'd4);
      for (int k = 0; k < 2; k++) begin
         n++;
         step(1'b0, 8'd0, 1'b1, fwd5(n));
      end
      chk("s5_rate_pulses", 32'(rate_pulses - base), 32'd2);

      // Reset in the middle of DRAIN
      do_reset();
      base = rate_pulses;
      step(1'b1, 8'd5, 1'b1, 1'b1);
      for (int k = 1; k <= 3; k++) step(1'b0, 8'd0, 1'b1, 1'b1);
      chk("s6_in_drain", 32'(s_axis_in_tready), 32'd0);
      reset_n = 1'b0;
      step(1'b0, 8'd0, 1'b0, 1'b1);
      reset_n = 1'b1;
      chk("s6_busy", 32'(busy), 32'd0);
      chk("s6_in_tready", 32'(s_axis_in_tready), 32'd1);
      chk("s6_cfg_tready", 32'(s_axis_cfg_tready), 32'd1);
      chk("s6_cur_rate", 32'(cur_rate), 32'd10);
      chk("s6_rate_tvalid", 32'(m_axis_rate_tvalid), 32'd0);
      chk("s6_out_tvalid", 32'(m_axis_out_tvalid), 32'd0);
      repeat (12) step(1'b0, 8'd0, 1'b0, 1'b1);
      chk("s6_rate_pulses", 32'(rate_pulses - base), 32'd0);
      chk("s6_busy_after", 32'(busy), 32'd0);

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
